// File: rtl/vme_cmd_pkg.sv
// Shared types and constants for the VME A24/D16 command master.
package vme_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int CMD_RD_BIT      = 25;
  localparam int CMD_WR_BIT      = 24;
  localparam int ERR_TIMEOUT_BIT = 16;
  localparam int ERR_ILLEGAL_BIT = 17;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
  localparam logic [5:0]  DEF_AM_CODE  = 6'h39;

  // Builds the completion word reported on dat_out.
  function automatic logic [31:0] pack_result(input logic tmo, input logic ill,
                                              input logic [15:0] data);
    logic [31:0] r;
    r                  = '0;
    r[15:0]            = data;
    r[ERR_TIMEOUT_BIT] = tmo;
    r[ERR_ILLEGAL_BIT] = ill;
    return r;
  endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchroniser for the asynchronous, active-low DTACK; idles released (1).
module vme_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_p0 <= 1'b1;
      q    <= 1'b1;
    end else begin
      q_p0 <= d;
      q    <= q_p0;
    end
  end

endmodule

// File: rtl/vme_cmd_master.sv
// VME A24/D16 master: runs one bus cycle per accepted command and reports the
// result (read data, write echo, timeout or illegal flag) with a dat_wr strobe.
module vme_cmd_master
  import vme_cmd_pkg::*;
#(
  parameter int          SETUP_CYC = 2,
  parameter int          TIMEOUT   = 255,
  parameter logic [5:0]  AM_CODE   = DEF_AM_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cmd_reg,
  input  logic [31:0] dat_in,
  output logic        cmd_rd,
  output logic        dat_wr,
  output logic [31:0] dat_out,
  output logic [22:0] vme_addr,
  output logic [5:0]  vme_am,
  output logic        vme_as_b,
  output logic [1:0]  vme_ds_b,
  output logic        vme_write_b,
  output logic [15:0] vme_data_out,
  output logic        vme_data_oe,
  input  logic [15:0] vme_data_in,
  input  logic        vme_dtack_b
);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic        rdy_q;
  logic        op_rd_q;
  logic [22:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [31:0] dout_q, dout_n;
  logic        dtack_s;
  logic        setup_done;
  logic        tmo;
  logic        accept;
  logic        in_bus;
  logic        unused_bits;

  assign unused_bits = ^{cmd_reg[31:26], cmd_reg[0], dat_in[31:16]};

  vme_sync2 u_dtack_sync (
    .clk (clk),
    .rst (rst),
    .d   (vme_dtack_b),
    .q   (dtack_s)
  );

  assign setup_done = (int'(cnt) >= SETUP_CYC - 1);
  assign tmo        = (int'(cnt) >= TIMEOUT - 1);
  assign accept     = (state == ST_IDLE) && rdy_q && start;
  assign in_bus     = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_RELEASE);

  always_comb begin
    state_n = state;
    dout_n  = dout_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_reg[CMD_RD_BIT] || cmd_reg[CMD_WR_BIT]) begin
            state_n = ST_SETUP;
          end else begin
            state_n = ST_DONE;
            dout_n  = pack_result(1'b0, 1'b1, 16'h0000);
          end
        end
      end
      ST_SETUP: begin
        // A DTACK still held by the previous slave blocks the strobe.
        if (setup_done && dtack_s) begin
          state_n = ST_STROBE;
        end else if (tmo) begin
          state_n = ST_DONE;
          dout_n  = pack_result(1'b1, 1'b0, TIMEOUT_DATA);
        end
      end
      ST_STROBE: begin
        if (!dtack_s) begin
          state_n = ST_RELEASE;
        end else if (tmo) begin
          state_n = ST_DONE;
          dout_n  = pack_result(1'b1, 1'b0, TIMEOUT_DATA);
        end
      end
      ST_RELEASE: begin
        if (dtack_s) begin
          state_n = ST_DONE;
          dout_n  = pack_result(1'b0, 1'b0, op_rd_q ? rdata_q : wdata_q);
        end else if (tmo) begin
          state_n = ST_DONE;
          dout_n  = pack_result(1'b1, 1'b0, TIMEOUT_DATA);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      rdy_q   <= 1'b0;
      op_rd_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state  <= state_n;
      rdy_q  <= (state_n == ST_IDLE);
      dout_q <= dout_n;
      // Counter restarts on every state entry and only runs during bus states.
      if ((state_n != state) || !in_bus) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
      if (accept) begin
        op_rd_q <= cmd_reg[CMD_RD_BIT];
        addr_q  <= cmd_reg[23:1];
        wdata_q <= dat_in[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_STROBE) && !dtack_s && op_rd_q) begin
      rdata_q <= vme_data_in;
    end
  end

  assign cmd_rd       = rdy_q;
  assign dat_wr       = (state == ST_DONE);
  assign dat_out      = dout_q;
  assign vme_addr     = addr_q;
  assign vme_am       = AM_CODE;
  assign vme_as_b     = (state != ST_STROBE);
  assign vme_ds_b     = {2{state != ST_STROBE}};
  assign vme_write_b  = !(in_bus && !op_rd_q);
  assign vme_data_out = wdata_q;
  assign vme_data_oe  = !op_rd_q && ((state == ST_SETUP) || (state == ST_STROBE));

endmodule

// File: tb/tb_vme_cmd_master.sv
// Bench for vme_cmd_master: table-driven and random commands against a
// behavioural slave and a result/latency reference model.
module tb_vme_cmd_master;

  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 255;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] cmd_reg;
  logic [31:0] dat_in;
  logic        cmd_rd;
  logic        dat_wr;
  logic [31:0] dat_out;
  logic [22:0] vme_addr;
  logic [5:0]  vme_am;
  logic        vme_as_b;
  logic [1:0]  vme_ds_b;
  logic        vme_write_b;
  logic [15:0] vme_data_out;
  logic        vme_data_oe;
  logic [15:0] vme_data_in;
  logic        vme_dtack_b;

  vme_cmd_master #(.SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT), .AM_CODE(6'h39)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmd_reg      (cmd_reg),
    .dat_in       (dat_in),
    .cmd_rd       (cmd_rd),
    .dat_wr       (dat_wr),
    .dat_out      (dat_out),
    .vme_addr     (vme_addr),
    .vme_am       (vme_am),
    .vme_as_b     (vme_as_b),
    .vme_ds_b     (vme_ds_b),
    .vme_write_b  (vme_write_b),
    .vme_data_out (vme_data_out),
    .vme_data_oe  (vme_data_oe),
    .vme_data_in  (vme_data_in),
    .vme_dtack_b  (vme_dtack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: DTACK after dly clocks of DS low (dly<0: never), released with DS.
  logic        stale = 1'b0;
  int          dly   = 0;
  logic [15:0] sd    = 16'h0;
  int          ds_cnt = 0;

  always @(posedge clk) begin
    if (vme_ds_b == 2'b00) ds_cnt <= ds_cnt + 1;
    else                   ds_cnt <= 0;
  end

  always_comb begin
    vme_dtack_b = 1'b1;
    if (stale) vme_dtack_b = 1'b0;
    else if (dly >= 0 && vme_ds_b == 2'b00 && ds_cnt >= dly) vme_dtack_b = 1'b0;
  end

  assign vme_data_in = sd;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference result of one command; d<0 means the slave never answers.
  function automatic logic [31:0] ref_result(input logic [31:0] cmd, input logic [31:0] din,
                                             input logic [15:0] sdat, input int d);
    if (cmd[25]) return (d < 0) ? 32'h0001_DEAD : {16'h0, sdat};
    if (cmd[24]) return (d < 0) ? 32'h0001_DEAD : {16'h0, din[15:0]};
    return 32'h0002_0000;
  endfunction

  task automatic run_cmd(input string nm, input logic [31:0] cmd, input logic [31:0] din,
                         input logic [15:0] sdat, input int d, input int stale_n,
                         input bit busy_pulse, input logic [31:0] exp);
    int n, wr_cnt, lat, first_as, as_low, bad_bus, exp_first, exp_lat;
    logic oe_at_wr;
    logic [31:0] dout;
    bit legal;
    legal = cmd[25] | cmd[24];
    n = 0;
    while (!cmd_rd && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " ready"}, {31'h0, cmd_rd}, 32'h1);
    dly = d; sd = sdat; cmd_reg = cmd; dat_in = din; start = 1'b1;
    n = 0; wr_cnt = 0; lat = 0; first_as = 0; as_low = 0; bad_bus = 0;
    oe_at_wr = 1'b0; dout = '0;
    while (n < 600) begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
      if (busy_pulse && n == 3) begin start = 1'b1; cmd_reg = 32'h0; end
      if (busy_pulse && n == 4) start = 1'b0;
      if (stale_n > 0 && n == stale_n) stale = 1'b0;
      if (vme_as_b == 1'b0) begin
        as_low++;
        if (first_as == 0) first_as = n;
        if (vme_addr !== cmd[23:1] || vme_ds_b !== 2'b00 || vme_write_b !== cmd[25]) bad_bus++;
        if (!cmd[25] && (vme_data_oe !== 1'b1 || vme_data_out !== din[15:0])) bad_bus++;
        if (cmd[25] && vme_data_oe !== 1'b0) bad_bus++;
      end
      if (dat_wr) begin
        wr_cnt++; lat = n; dout = dat_out; oe_at_wr = vme_data_oe;
      end
      if (wr_cnt > 0 && cmd_rd) break;
    end
    check({nm, " dat_wr count"}, wr_cnt, 1);
    check({nm, " dat_out"}, dout, exp);
    if (legal) begin
      exp_first = (stale_n > 0) ? stale_n + 3 : SETUP_CYC + 1;
      exp_lat   = (d < 0) ? exp_first + TIMEOUT : exp_first + 6 + d;
      check({nm, " first AS cycle"}, first_as, exp_first);
      check({nm, " bus signals"}, bad_bus, 0);
      check({nm, " oe at dat_wr"}, {31'h0, oe_at_wr}, 32'h0);
      check({nm, " latency"}, lat, exp_lat);
      if (d < 0) check({nm, " AS low clocks"}, as_low, TIMEOUT);
    end else begin
      check({nm, " AS low clocks"}, as_low, 0);
      check({nm, " latency<=2"}, {31'h0, (lat >= 1 && lat <= 2)}, 32'h1);
    end
    repeat (3) @(posedge clk);
    #1;
    check({nm, " dat_out hold"}, dat_out, exp);
    check({nm, " cmd_rd after"}, {31'h0, cmd_rd}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] din;
    logic [15:0] sdat;
    int          d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int wr;
    logic [31:0] r_cmd, r_din;
    logic [15:0] r_sd;
    int r_d;

    tbl[0] = '{32'h02A8_4100, 32'h0000_0000, 16'h1234, 3, 32'h0000_1234};
    tbl[1] = '{32'h01A8_1000, 32'h0000_BEEF, 16'h5555, 0, 32'h0000_BEEF};
    tbl[2] = '{32'h00A8_0000, 32'h1234_5678, 16'h0000, 0, 32'h0002_0000};
    tbl[3] = '{32'h0300_0002, 32'hFFFF_1111, 16'hCAFE, 1, 32'h0000_CAFE};
    tbl[4] = '{32'h01FF_FFFE, 32'hABCD_7777, 16'h0F0F, 2, 32'h0000_7777};

    rst = 1'b1; start = 1'b0; cmd_reg = '0; dat_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_rd", {31'h0, cmd_rd}, 32'h0);
    check("rst dat_wr", {31'h0, dat_wr}, 32'h0);
    check("rst dat_out", dat_out, 32'h0);
    check("rst vme_addr", {9'h0, vme_addr}, 32'h0);
    check("rst vme_am", {26'h0, vme_am}, 32'h39);
    check("rst as_b", {31'h0, vme_as_b}, 32'h1);
    check("rst ds_b", {30'h0, vme_ds_b}, 32'h3);
    check("rst write_b", {31'h0, vme_write_b}, 32'h1);
    check("rst data_out", {16'h0, vme_data_out}, 32'h0);
    check("rst data_oe", {31'h0, vme_data_oe}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("cmd_rd after rst", {31'h0, cmd_rd}, 32'h1);

    for (int i = 0; i < 5; i++)
      run_cmd($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].din, tbl[i].sdat, tbl[i].d, 0, 1'b0,
              tbl[i].exp);

    run_cmd("timeout", 32'h0200_0010, 32'h0, 16'h7777, -1, 0, 1'b0, 32'h0001_DEAD);

    stale = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_cmd("stale+busy", 32'h0112_3456, 32'h0000_A5A5, 16'h0, 0, 6, 1'b1, 32'h0000_A5A5);

    for (int i = 0; i < 25; i++) begin
      r_cmd = $urandom; r_din = $urandom; r_sd = 16'($urandom);
      r_d = $urandom_range(0, 3);
      run_cmd($sformatf("rand%0d", i), r_cmd, r_din, r_sd, r_d, 0, 1'b0,
              ref_result(r_cmd, r_din, r_sd, r_d));
    end

    // Reset while a write is strobing the bus.
    dly = 40; cmd_reg = 32'h0100_0100; dat_in = 32'h0000_1111; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!vme_as_b) break;
    end
    check("midrst as low before", {31'h0, vme_as_b}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst as_b", {31'h0, vme_as_b}, 32'h1);
    check("midrst ds_b", {30'h0, vme_ds_b}, 32'h3);
    check("midrst oe", {31'h0, vme_data_oe}, 32'h0);
    check("midrst dat_wr", {31'h0, dat_wr}, 32'h0);
    check("midrst cmd_rd", {31'h0, cmd_rd}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst cmd_rd after", {31'h0, cmd_rd}, 32'h1);
    check("midrst dat_out", dat_out, 32'h0);
    wr = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dat_wr) wr++;
    end
    check("midrst no dat_wr", wr, 0);

    run_cmd("post-rst read", tbl[0].cmd, tbl[0].din, tbl[0].sdat, tbl[0].d, 0, 1'b0, tbl[0].exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
